instruction_fetch_unit: RTL and testbench

- IF stage of the 16-bit pipelined TSC CPU.
- Holds the PC and drives the instruction-memory read handshake.
- Predicts the next PC with a direct-mapped branch target buffer (BTB).
- Presents pc_IF, branch_predicted_pc_IF and instruction_IF, plus a valid flag, to the IF/ID pipeline register; accepts stall and EX-stage redirects.

---
 rtl/instruction_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// IF stage of the 16-bit TSC pipeline: owns the PC, runs the instruction-memory
// read handshake and predicts the next PC from a direct-mapped BTB.
module instruction_fetch_unit #(
    parameter int                   WORD_SIZE      = 16,
    parameter int                   BTB_INDEX_BITS = 3,
    parameter logic [WORD_SIZE-1:0] RESET_PC       = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 btb_update,
    input  logic [WORD_SIZE-1:0] btb_update_pc,
    input  logic [WORD_SIZE-1:0] btb_update_target,
    input  logic                 btb_update_taken,
    output logic [WORD_SIZE-1:0] pc_IF,
    output logic [WORD_SIZE-1:0] branch_predicted_pc_IF,
    output logic [WORD_SIZE-1:0] instruction_IF,
    output logic                 if_valid,
    output logic                 o_dbg_state
);

    localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
    localparam int TAG_BITS    = WORD_SIZE - BTB_INDEX_BITS;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WORD_SIZE-1:0]   r_pc;
    logic [WORD_SIZE-1:0]   r_hold;
    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [TAG_BITS-1:0]    r_btb_tag    [BTB_ENTRIES];
    logic [WORD_SIZE-1:0]   r_btb_target [BTB_ENTRIES];

    logic [BTB_INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]       w_tag;
    logic [BTB_INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]       w_upd_tag;
    logic                      w_hit;
    logic [WORD_SIZE-1:0]      w_next_pc;
    logic                      w_have_instr;

    assign w_idx     = r_pc[BTB_INDEX_BITS-1:0];
    assign w_tag     = r_pc[WORD_SIZE-1:BTB_INDEX_BITS];
    assign w_upd_idx = btb_update_pc[BTB_INDEX_BITS-1:0];
    assign w_upd_tag = btb_update_pc[WORD_SIZE-1:BTB_INDEX_BITS];

    // Full-tag compare only; an aliased index with a different tag falls through to pc + 1.
    assign w_hit     = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
    assign w_next_pc = w_hit ? r_btb_target[w_idx] : r_pc + WORD_SIZE'(1);

    assign w_have_instr = (r_state == S_HOLD) || i_ready;

    // Outputs are gated by reset directly so they drop the moment reset asserts.
    assign i_readM                = !reset && (r_state == S_REQ);
    assign i_address              = r_pc;
    assign pc_IF                  = r_pc;
    assign branch_predicted_pc_IF = w_next_pc;
    assign if_valid               = !reset && !redirect && w_have_instr;
    assign o_dbg_state            = r_state;

    always_comb begin
        instruction_IF = '0;
        if (!reset) begin
            if (r_state == S_HOLD)
                instruction_IF = r_hold;
            else if (i_ready)
                instruction_IF = i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_hold  <= '0;
        end else if (redirect) begin
            r_state <= S_REQ;
            r_pc    <= redirect_pc;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_ready) begin
                        if (stall) begin
                            r_hold  <= i_data;
                            r_state <= S_HOLD;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_pc    <= w_next_pc;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_btb_valid <= '0;
        else if (btb_update)
            r_btb_valid[w_upd_idx] <= btb_update_taken;
    end

    // Tag/target need no reset: they are only read when the valid bit is set.
    always_ff @(posedge clk) begin
        if (btb_update && btb_update_taken) begin
            r_btb_tag[w_upd_idx]    <= w_upd_tag;
            r_btb_target[w_upd_idx] <= btb_update_target;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: stimulus pushes expected fetches,
// a negedge monitor pops and compares whenever if_valid is presented.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        btb_update;
    logic [15:0] btb_update_pc;
    logic [15:0] btb_update_target;
    logic        btb_update_taken;
    logic [15:0] pc_IF;
    logic [15:0] branch_predicted_pc_IF;
    logic [15:0] instruction_IF;
    logic        if_valid;
    logic        o_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [47:0] exp_q[$];

    instruction_fetch_unit dut (
        .clk                    (clk),
        .reset                  (reset),
        .i_readM                (i_readM),
        .i_address              (i_address),
        .i_data                 (i_data),
        .i_ready                (i_ready),
        .stall                  (stall),
        .redirect               (redirect),
        .redirect_pc            (redirect_pc),
        .btb_update             (btb_update),
        .btb_update_pc          (btb_update_pc),
        .btb_update_target      (btb_update_target),
        .btb_update_taken       (btb_update_taken),
        .pc_IF                  (pc_IF),
        .branch_predicted_pc_IF (branch_predicted_pc_IF),
        .instruction_IF         (instruction_IF),
        .if_valid               (if_valid),
        .o_dbg_state            (o_dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign i_data = mem_f(i_address);

    // Driver tasks
    task automatic step(input logic rdy, input logic stl, input logic rd, input logic [15:0] rpc,
                        input logic bu, input logic [15:0] bpc, input logic [15:0] btgt,
                        input logic btk);
        @(posedge clk);
        #1;
        i_ready           = rdy;
        stall             = stl;
        redirect          = rd;
        redirect_pc       = rpc;
        btb_update        = bu;
        btb_update_pc     = bpc;
        btb_update_target = btgt;
        btb_update_taken  = btk;
    endtask

    task automatic fetch(input logic rdy, input logic stl);
        step(rdy, stl, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic push_exp(input logic [15:0] pc, input logic [15:0] pred);
        exp_q.push_back({pc, pred, mem_f(pc)});
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [47:0] e;
        if (!reset && if_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: pc_IF %h with empty queue", pc_IF);
            end else begin
                e = exp_q.pop_front();
                if (pc_IF !== e[47:32] || branch_predicted_pc_IF !== e[31:16] ||
                    instruction_IF !== e[15:0]) begin
                    n_bad++;
                    $display("FAIL fetch: got pc %h pred %h instr %h expected pc %h pred %h instr %h",
                             pc_IF, branch_predicted_pc_IF, instruction_IF,
                             e[47:32], e[31:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        i_ready = 0; stall = 0; redirect = 0; redirect_pc = '0;
        btb_update = 0; btb_update_pc = '0; btb_update_target = '0; btb_update_taken = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readM", 16'(i_readM), 16'h0);
        chk("rst_valid", 16'(if_valid), 16'h0);
        chk("rst_pc", pc_IF, 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;

        // Test 1: reset while waiting at pc 3
        fetch(1, 0); push_exp(16'h0000, 16'h0001);
        fetch(1, 0); push_exp(16'h0001, 16'h0002);
        fetch(1, 0); push_exp(16'h0002, 16'h0003);
        fetch(0, 0);
        @(negedge clk);
        chk("t1_pc3", pc_IF, 16'h0003);
        chk("t1_readM_before", 16'(i_readM), 16'h1);
        reset = 1'b1;
        #1;
        chk("t1_readM_rst", 16'(i_readM), 16'h0);
        chk("t1_valid_rst", 16'(if_valid), 16'h0);
        chk("t1_instr_rst", instruction_IF, 16'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t1_pc_after", pc_IF, 16'h0000);
        chk("t1_readM_after", 16'(i_readM), 16'h1);

        // Test 2: two-cycle memory latency, empty BTB
        for (int k = 0; k < 4; k++) begin
            fetch(0, 0);
            @(negedge clk);
            chk("t2_wait_valid", 16'(if_valid), 16'h0);
            chk("t2_wait_pc", pc_IF, 16'(k));
            fetch(1, 0); push_exp(16'(k), 16'(k + 1));
        end

        // Test 3: stall at pc 4
        fetch(1, 1); push_exp(16'h0004, 16'h0005);
        for (int k = 0; k < 2; k++) begin
            fetch(0, 1); push_exp(16'h0004, 16'h0005);
            @(negedge clk);
            chk("t3_hold_readM", 16'(i_readM), 16'h0);
            chk("t3_hold_state", 16'(o_dbg_state), 16'h1);
        end
        fetch(0, 0); push_exp(16'h0004, 16'h0005);
        fetch(0, 0);
        @(negedge clk);
        chk("t3_next_pc", pc_IF, 16'h0005);
        chk("t3_state_req", 16'(o_dbg_state), 16'h0);

        // Test 4: BTB install, alias miss, invalidate
        step(0, 0, 0, 16'h0, 1, 16'h0005, 16'h0020, 1);
        @(negedge clk);
        chk("t4_old_pred", branch_predicted_pc_IF, 16'h0006);
        fetch(1, 0); push_exp(16'h0005, 16'h0020);
        fetch(0, 0);
        @(negedge clk);
        chk("t4_taken_pc", pc_IF, 16'h0020);
        step(1, 0, 1, 16'h000D, 0, 16'h0, 16'h0, 0);
        @(negedge clk);
        chk("t4_redir_valid", 16'(if_valid), 16'h0);
        fetch(1, 0); push_exp(16'h000D, 16'h000E);
        step(0, 0, 1, 16'h0005, 1, 16'h0005, 16'h0000, 0);
        @(negedge clk);
        chk("t4_redir2_valid", 16'(if_valid), 16'h0);
        fetch(1, 0); push_exp(16'h0005, 16'h0006);

        // Test 5: redirect while waiting, then while held under stall
        fetch(0, 0);
        step(0, 0, 1, 16'h0040, 0, 16'h0, 16'h0, 0);
        @(negedge clk);
        chk("t5_wait_valid", 16'(if_valid), 16'h0);
        fetch(0, 0);
        @(negedge clk);
        chk("t5_addr40", i_address, 16'h0040);
        chk("t5_state40", 16'(o_dbg_state), 16'h0);
        fetch(1, 1); push_exp(16'h0040, 16'h0041);
        step(0, 1, 1, 16'h0050, 0, 16'h0, 16'h0, 0);
        @(negedge clk);
        chk("t5_hold_valid", 16'(if_valid), 16'h0);
        fetch(0, 0);
        @(negedge clk);
        chk("t5_addr50", i_address, 16'h0050);
        chk("t5_state50", 16'(o_dbg_state), 16'h0);
        chk("t5_readM50", 16'(i_readM), 16'h1);
        fetch(1, 0); push_exp(16'h0050, 16'h0051);

        // Test 6: PC wrap
        step(0, 0, 1, 16'hFFFF, 0, 16'h0, 16'h0, 0);
        fetch(1, 0); push_exp(16'hFFFF, 16'h0000);
        fetch(0, 0);
        @(negedge clk);
        chk("t6_wrap_addr", i_address, 16'h0000);
        fetch(1, 0); push_exp(16'h0000, 16'h0001);
        fetch(0, 0);
        @(negedge clk);
        @(negedge clk);

        chk("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
